sr_bank: RTL and testbench

Parametrised multi-channel set/reset flip-flop bank, successor to the single-bit SR flip-flop. WIDTH independent SR channels share one clock, enable and asynchronous reset. The S=R=1 resolution is selectable at elaboration. The block adds per-channel change pulses, a sticky conflict flag and saturating per-channel transition counters. It sits between status/event sources and the control logic that latches and audits them.

---
 rtl/sr_bank_pkg.sv | 29 ++
 rtl/sr_bank_sync2.sv | 27 ++
 rtl/sr_bank.sv | 104 ++++++++++
 tb/tb_sr_bank.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sr_bank_pkg.sv
// sr_bank_pkg: shared constants and the per-channel next-state function for sr_bank.
package sr_bank_pkg;

  // How a channel resolves s=1,r=1.
  localparam int MODE_HOLD    = 0;
  localparam int MODE_SET_DOM = 1;
  localparam int MODE_RST_DOM = 2;
  localparam int MODE_TOGGLE  = 3;

  // Next state of one SR channel, given its current state and the resolution mode.
  function automatic logic next_q(input logic s, input logic r, input logic q, input int mode);
    logic nq;
    nq = q;
    if (s && !r) begin
      nq = 1'b1;
    end else if (!s && r) begin
      nq = 1'b0;
    end else if (s && r) begin
      case (mode)
        MODE_SET_DOM: nq = 1'b1;
        MODE_RST_DOM: nq = 1'b0;
        MODE_TOGGLE:  nq = ~q;
        default:      nq = q;
      endcase
    end
    return nq;
  endfunction

endpackage

// File: rtl/sr_bank_sync2.sv
// sr_sync2: WIDTH-wide two-flop synchroniser, async active-low reset clears both stages.
module sr_sync2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two back-to-back stages; only the second stage is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/sr_bank.sv
// sr_bank: WIDTH independent SR flip-flops with change pulses, sticky conflict
// flag and saturating per-channel transition counters.
// Build option: define SR_BANK_INPUT_SYNC_EN to pass s/r through a two-flop
// synchroniser (s/r to q latency becomes 3 cycles; en is not synchronised).
module sr_bank
  import sr_bank_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               MODE      = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 8,
  localparam int              SEL_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] chg,
  output logic             conflict,
  input  logic             conflict_clr,
  input  logic [SEL_W-1:0] cnt_sel,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_out
);

  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_r;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_chg;
  logic [CNT_W-1:0] w_cnt [WIDTH];
  logic             r_conflict;

`ifdef SR_BANK_INPUT_SYNC_EN
  sr_sync2 #(.WIDTH(WIDTH)) u_sync_s (.clk(clk), .rst_n(rst_n), .d(s), .q(w_s));
  sr_sync2 #(.WIDTH(WIDTH)) u_sync_r (.clk(clk), .rst_n(rst_n), .d(r), .q(w_r));
`else
  assign w_s = s;
  assign w_r = r;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic             r_q;
    logic             r_chg;
    logic [CNT_W-1:0] r_cnt;
    logic             w_next;
    logic             w_flip;

    assign w_next = next_q(w_s[i], w_r[i], r_q, MODE);
    assign w_flip = en && (w_next != r_q);

    // Channel state, change pulse and transition counter (clear beats increment).
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q   <= RESET_VAL[i];
        r_chg <= 1'b0;
        r_cnt <= '0;
      end else begin
        if (en) begin
          r_q <= w_next;
        end
        r_chg <= w_flip;
        if (cnt_clr) begin
          r_cnt <= '0;
        end else if (w_flip && (r_cnt != {CNT_W{1'b1}})) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_q[i]   = r_q;
    assign w_chg[i] = r_chg;
    assign w_cnt[i] = r_cnt;
  end

  // Sticky conflict flag; a new conflict outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict <= 1'b0;
    end else if (en && (|(w_s & w_r))) begin
      r_conflict <= 1'b1;
    end else if (conflict_clr) begin
      r_conflict <= 1'b0;
    end
  end

  // Counter readback; selects past the last channel read as zero.
  always_comb begin
    cnt_out = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt_sel == SEL_W'(i)) begin
        cnt_out = w_cnt[i];
      end
    end
  end

  assign q        = w_q;
  assign qb       = ~w_q;
  assign chg      = w_chg;
  assign conflict = r_conflict;

endmodule

// File: tb/tb_sr_bank.sv
// tb_sr_bank: four sr_bank instances (one per MODE) share the same stimulus;
// directed vectors with hand-computed expectations.
module tb_sr_bank;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] s;
  logic [3:0] r;
  logic       conflict_clr;
  logic       cnt_clr;
  logic [1:0] cnt_sel;

  logic [3:0] q_m   [4];
  logic [3:0] qb_m  [4];
  logic [3:0] chg_m [4];
  logic [3:0] cnt_m [4];
  logic [3:0] conflict_m;

  int total;
  int bad;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sr_bank #(.WIDTH(4), .MODE(g), .RESET_VAL(4'b0101), .CNT_W(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r),
      .q(q_m[g]), .qb(qb_m[g]), .chg(chg_m[g]), .conflict(conflict_m[g]),
      .conflict_clr(conflict_clr), .cnt_sel(cnt_sel), .cnt_clr(cnt_clr),
      .cnt_out(cnt_m[g])
    );
  end

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present inputs for one edge, then sample 1 time unit after it.
  task automatic cycle(input logic [3:0] sv, input logic [3:0] rv,
                       input logic en_v, input logic ccl, input logic kcl);
    s = sv; r = rv; en = en_v; conflict_clr = ccl; cnt_clr = kcl;
    @(posedge clk);
    #1;
    s = '0; r = '0; en = 1'b1; conflict_clr = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s actual=%b required=%b", name, act, exp_v);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int m = 0; m < 4; m++) begin
      chk4("reset_q", q_m[m], 4'b0101);
      chk4("reset_qb", qb_m[m], 4'b1010);
      chk4("reset_chg", chg_m[m], 4'b0000);
    end
    chk4("reset_conflict", conflict_m, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      cnt_sel = 2'(k);
      #1;
      chk4("reset_cnt", cnt_m[0], 4'd0);
    end
    cnt_sel = 2'd0;
    #17 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk4("idle_q", q_m[0], 4'b0101);
    chk4("idle_chg", chg_m[0], 4'b0000);
    chk4("idle_conflict", conflict_m, 4'b0000);
  endtask

  task automatic test_basic();
    cycle(4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0);
    chk4("set_q", q_m[0], 4'b0111);
    chk4("set_qb", qb_m[0], 4'b1000);
    chk4("set_chg", chg_m[0], 4'b0010);
    cycle(4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0);
    chk4("rst_q", q_m[0], 4'b0110);
    chk4("rst_chg", chg_m[0], 4'b0001);
    cnt_sel = 2'd1; #1;
    chk4("cnt_ch1", cnt_m[0], 4'd1);
    cnt_sel = 2'd0; #1;
    chk4("cnt_ch0", cnt_m[0], 4'd1);
    cycle(4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0);
    chk4("reset_already_set_q", q_m[0], 4'b0110);
    chk4("no_chg_on_reset_set", chg_m[0], 4'b0000);
    chk4("no_conflict_yet", conflict_m, 4'b0000);
  endtask

  task automatic test_conflict_modes();
    cycle(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);
    chk4("clear_all_q", q_m[0], 4'b0000);
    cycle(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1);
    cnt_sel = 2'd3;
    cycle(4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0);
    chk4("hold_q", q_m[0], 4'b0000);
    chk4("hold_chg", chg_m[0], 4'b0000);
    chk4("setdom_q", q_m[1], 4'b1000);
    chk4("rstdom_q", q_m[2], 4'b0000);
    chk4("toggle_q1", q_m[3], 4'b1000);
    chk4("toggle_chg1", chg_m[3], 4'b1000);
    chk4("conflict_all_modes", conflict_m, 4'b1111);
    cycle(4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0);
    chk4("toggle_q2", q_m[3], 4'b0000);
    chk4("setdom_hold_q", q_m[1], 4'b1000);
    cycle(4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0);
    chk4("toggle_q3", q_m[3], 4'b1000);
    chk4("toggle_cnt", cnt_m[3], 4'd3);
    chk4("setdom_cnt", cnt_m[1], 4'd1);
    chk4("hold_cnt", cnt_m[0], 4'd0);
  endtask

  task automatic test_enable_clears();
    cycle(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);
    chk4("conflict_clr", conflict_m, 4'b0000);
    cycle(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);
    cycle(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
    for (int m = 0; m < 4; m++) begin
      chk4("en_low_q", q_m[m], 4'b0000);
      chk4("en_low_chg", chg_m[m], 4'b0000);
    end
    cycle(4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0);
    chk4("en_low_no_conflict", conflict_m, 4'b0000);
    cycle(4'b0001, 4'b0001, 1'b1, 1'b1, 1'b0);
    chk4("conflict_set_wins", conflict_m, 4'b1111);
    chk4("hold_q_after_conflict", q_m[0], 4'b0000);
    cycle(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);
    chk4("conflict_clr2", conflict_m, 4'b0000);
    cnt_sel = 2'd1;
    cycle(4'b0010, 4'b0000, 1'b1, 1'b0, 1'b1);
    chk4("clr_vs_inc_q", q_m[0], 4'b0010);
    chk4("clr_vs_inc_cnt", cnt_m[0], 4'd0);
    cycle(4'b0000, 4'b0010, 1'b1, 1'b0, 1'b0);
    chk4("cnt_after_clr", cnt_m[0], 4'd1);
  endtask

  task automatic test_saturation();
    cnt_sel = 2'd0;
    cycle(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1);
    chk4("sat_start", cnt_m[3], 4'd0);
    repeat (20) cycle(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0);
    chk4("sat_cnt", cnt_m[3], 4'd15);
    repeat (3) cycle(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0);
    chk4("sat_hold", cnt_m[3], 4'd15);
    chk4("sat_hold_mode_cnt", cnt_m[0], 4'd0);
    s = 4'b0001; r = 4'b0001;
    #2 rst_n = 1'b0;
    #1;
    chk4("async_rst_q", q_m[3], 4'b0101);
    chk4("async_rst_cnt", cnt_m[3], 4'd0);
    chk4("async_rst_chg", chg_m[3], 4'b0000);
    chk4("async_rst_conflict", conflict_m, 4'b0000);
    s = '0; r = '0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk4("after_rst_q", q_m[3], 4'b0101);
  endtask

  task automatic test_sync();
    s = 4'b0010;
    @(posedge clk); #1; s = '0;
    chk4("sync_lat_k", q_m[0], 4'b0101);
    @(posedge clk); #1;
    chk4("sync_lat_k1", q_m[0], 4'b0101);
    @(posedge clk); #1;
    chk4("sync_lat_k2_q", q_m[0], 4'b0111);
    chk4("sync_lat_k2_chg", chg_m[0], 4'b0010);
    #1 s = 4'b0100;
    #2 s = 4'b0000;
    repeat (4) @(posedge clk);
    #1;
    chk4("sync_glitch", q_m[0], 4'b0111);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b1; en = 1'b1; s = '0; r = '0;
    conflict_clr = 1'b0; cnt_clr = 1'b0; cnt_sel = '0;
    test_reset();
`ifdef SR_BANK_INPUT_SYNC_EN
    test_sync();
`else
    test_basic();
    test_conflict_modes();
    test_enable_clears();
    test_saturation();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
